// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input and flags stuck levels.
// Latency: valid after SYNC_STAGES+1 edges from the closing pwm_in rise; no backpressure, results simply overwrite.
module pwm_capture #(
    parameter int CTR_W       = 11,
    parameter int TIMEOUT     = 2047,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CTR_W-1:0] high_cnt,
    output logic [CTR_W-1:0] period_cnt,
    output logic             valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CTR_W-1:0] TMO = CTR_W'(TIMEOUT);
    localparam logic [CTR_W-1:0] ONE = CTR_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    state_t                 state_q;
    logic [CTR_W-1:0]       cnt_q;
    logic [CTR_W-1:0]       hi_len_q;
    logic [CTR_W-1:0]       high_cnt_q;
    logic [CTR_W-1:0]       period_cnt_q;
    logic                   valid_q;
    logic                   stuck_hi_q;
    logic                   stuck_lo_q;

    logic                   s;
    logic                   rise;
    logic                   fall;
    logic [CTR_W-1:0]       cnt_sat;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d_q;
    assign fall    = ~s & s_d_q;
    // Saturating at TIMEOUT keeps the counter from ever wrapping.
    assign cnt_sat = (cnt_q == TMO) ? TMO : cnt_q + ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q       <= '0;
            s_d_q        <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_len_q     <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            stuck_hi_q   <= 1'b0;
            stuck_lo_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d_q   <= s;
            valid_q <= 1'b0;

            if (fall) stuck_hi_q <= 1'b0;
            if (rise) stuck_lo_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rise) begin
                        state_q <= HIGH;
                        cnt_q   <= ONE;
                    end
                end
                HIGH: begin
                    // An edge arriving on the timeout cycle still counts as a measurement.
                    if (fall) begin
                        state_q  <= LOW;
                        hi_len_q <= cnt_q;
                        cnt_q    <= cnt_sat;
                    end else if (cnt_q == TMO) begin
                        state_q    <= IDLE;
                        stuck_hi_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_q      <= HIGH;
                        high_cnt_q   <= hi_len_q;
                        period_cnt_q <= cnt_q;
                        valid_q      <= 1'b1;
                        cnt_q        <= ONE;
                    end else if (cnt_q == TMO) begin
                        state_q    <= IDLE;
                        stuck_lo_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign valid      = valid_q;
    assign stuck_hi   = stuck_hi_q;
    assign stuck_lo   = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model, per-cycle compare, directed and jittered random stimulus.
`timescale 1ns/1ns
module tb_pwm_capture;

    localparam int CTR_W   = 11;
    localparam int TIMEOUT = 2047;
    localparam int SS      = 2;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CTR_W-1:0] high_cnt;
    logic [CTR_W-1:0] period_cnt;
    logic             valid;
    logic             stuck_hi;
    logic             stuck_lo;

    pwm_capture #(
        .CTR_W      (CTR_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .high_cnt  (high_cnt),
        .period_cnt(period_cnt),
        .valid     (valid),
        .stuck_hi  (stuck_hi),
        .stuck_lo  (stuck_lo)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    endtask

    function automatic logic [CTR_W-1:0] sat(input longint unsigned v);
        return (v > TIMEOUT) ? CTR_W'(TIMEOUT) : CTR_W'(v);
    endfunction

    // Reference model: remembers when the last rise and fall were seen and derives outputs from time differences.
    bit [SS:0]        hist;
    longint unsigned  cyc, t_rise, t_fall;
    bit               have_rise, fell, m_rise, m_fall;
    logic [CTR_W-1:0] m_high, m_period;
    logic             m_valid, m_shi, m_slo;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist = '0; cyc = 0; t_rise = 0; t_fall = 0;
            have_rise = 0; fell = 0;
            m_high = '0; m_period = '0; m_valid = 0; m_shi = 0; m_slo = 0;
        end else begin
            m_rise  = hist[SS-1] && !hist[SS];
            m_fall  = !hist[SS-1] && hist[SS];
            m_valid = 0;
            if (m_rise) begin
                if (have_rise && fell) begin
                    m_high   = sat(t_fall - t_rise);
                    m_period = sat(cyc - t_rise);
                    m_valid  = 1;
                end
                m_slo = 0; have_rise = 1; fell = 0; t_rise = cyc;
            end else if (m_fall) begin
                m_shi = 0;
                if (have_rise && !fell) begin
                    fell = 1; t_fall = cyc;
                end
            end else if (have_rise && (cyc - t_rise) >= TIMEOUT) begin
                if (fell) m_slo = 1;
                else      m_shi = 1;
                have_rise = 0;
            end
            hist = {hist[SS-1:0], pwm_in};
            cyc++;
        end
    end

    int   valid_cnt = 0, shi_events = 0, slo_events = 0, async_valids = 0;
    logic prev_shi = 0, prev_slo = 0;
    bit   async_on = 0;
    int   h_q[$];

    always @(negedge clk) begin
        check("high_cnt", high_cnt, m_high);
        check("period_cnt", period_cnt, m_period);
        check("valid", valid, m_valid);
        check("stuck_hi", stuck_hi, m_shi);
        check("stuck_lo", stuck_lo, m_slo);
        check("both_stuck", stuck_hi & stuck_lo, 0);
        if (valid === 1'b1) begin
            valid_cnt++;
            check("valid_invariant", (high_cnt >= 1 && high_cnt < period_cnt), 1);
            if (async_on) begin
                async_valids++;
                check_range("async_period", period_cnt, 1250, 1252);
                if (h_q.size() > 0) begin
                    check_range("async_high", high_cnt, h_q[0] - 1, h_q[0] + 1);
                    void'(h_q.pop_front());
                end else begin
                    check("async_high_queue_nonempty", 0, 1);
                end
            end
        end
        if (stuck_hi && !prev_shi) shi_events++;
        if (stuck_lo && !prev_slo) slo_events++;
        prev_shi = stuck_hi;
        prev_slo = stuck_lo;
    end

    // Level changes always land 5 ns after a rising edge, so each segment lasts exactly n samples.
    task automatic seg(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(posedge clk);
        #5;
    endtask

    task automatic check_outs(input string tag, input int vcnt, input longint hi, input longint per);
        check({tag, "_valid_count"}, valid_cnt, vcnt);
        check({tag, "_high"}, high_cnt, hi);
        check({tag, "_period"}, period_cnt, per);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t_base, t_r, t_f;
        int     hlen, jr, jf;

        #2 rst = 1'b0;
        #1;
        check("reset_high", high_cnt, 0);
        check("reset_period", period_cnt, 0);
        check("reset_valid", valid, 0);
        check("reset_stuck_hi", stuck_hi, 0);
        check("reset_stuck_lo", stuck_lo, 0);
        repeat (3) @(posedge clk);
        #5 rst = 1'b1;
        seg(0, 10);

        // 50% duty at the generator's 1251-cycle frame
        repeat (3) begin seg(1, 625); seg(0, 626); end
        seg(1, 1); seg(0, 20);
        check_outs("half_duty", 3, 625, 1251);
        check("half_duty_stuck_hi", stuck_hi, 0);
        check("half_duty_stuck_lo", stuck_lo, 0);

        // duty extremes
        seg(0, 1230);
        seg(1, 1); seg(0, 1250);
        seg(1, 20);
        check_outs("min_duty", 5, 1, 1251);
        seg(1, 1230); seg(0, 1);
        seg(1, 1250); seg(0, 1);
        seg(1, 20);
        check_outs("max_duty", 7, 1250, 1251);

        // stuck high
        seg(1, 2010);
        check("stuck_hi_early", stuck_hi, 0);
        seg(1, 40);
        check("stuck_hi_set", stuck_hi, 1);
        check("stuck_hi_events", shi_events, 1);
        check_outs("stuck_hi_hold", 7, 1250, 1251);
        seg(0, 2);
        check("stuck_hi_still", stuck_hi, 1);
        seg(0, 1);
        check("stuck_hi_cleared", stuck_hi, 0);
        seg(0, 197);
        seg(1, 100); seg(0, 200);
        check("after_idle_no_valid", valid_cnt, 7);
        seg(1, 20);
        check_outs("after_idle_meas", 8, 100, 300);

        // period boundary at TIMEOUT
        seg(1, 80); seg(0, 1947);
        seg(1, 20);
        check_outs("period_2047", 9, 100, 2047);
        check("period_2047_no_stuck", slo_events, 0);
        seg(1, 80); seg(0, 1948);
        seg(1, 20);
        check("period_2048_stuck_events", slo_events, 1);
        check("period_2048_stuck_cleared", stuck_lo, 0);
        check("period_2048_no_valid", valid_cnt, 9);
        seg(1, 80); seg(0, 1151);
        seg(1, 300);
        check_outs("post_stuck_lo", 10, 100, 1251);

        // asynchronous reset in the middle of a high phase
        #3 rst = 1'b0;
        #1;
        check("midrst_high", high_cnt, 0);
        check("midrst_period", period_cnt, 0);
        check("midrst_valid", valid, 0);
        check("midrst_stuck_hi", stuck_hi, 0);
        check("midrst_stuck_lo", stuck_lo, 0);
        seg(1, 100);
        pwm_in = 1'b0;
        repeat (10) @(posedge clk);
        #5 rst = 1'b1;
        seg(0, 40);
        seg(1, 625); seg(0, 626);
        check("post_reset_first_rise", valid_cnt, 10);
        seg(1, 20);
        check_outs("post_reset_meas", 11, 625, 1251);
        seg(1, 605); seg(0, 100);

        // jittered asynchronous edges, 50 complete periods of nominal 1251
        rst = 1'b0;
        #2 rst = 1'b1;
        h_q.delete();
        async_on = 1;
        @(posedge clk);
        t_base = $time + 5;
        for (int i = 0; i <= 50; i++) begin
            jr  = int'($urandom_range(18, 0)) - 4;
            t_r = t_base + longint'(i) * 1251 * 20 + jr;
            #(t_r - $time);
            pwm_in = 1'b1;
            if (i < 50) begin
                hlen = int'($urandom_range(1240, 10));
                jf   = int'($urandom_range(18, 0)) - 4;
                t_f  = t_base + longint'(i) * 1251 * 20 + longint'(hlen) * 20 + jf;
                #(t_f - $time);
                pwm_in = 1'b0;
                h_q.push_back(hlen);
            end
        end
        repeat (20) @(posedge clk);
        #5;
        check("async_valid_count", async_valids, 50);
        check("total_valid_count", valid_cnt, 61);
        async_on = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the 40 kHz PWM generator (50 MHz clk, 1251-cycle frame).
- Samples an asynchronous PWM input and measures the high time and period of each complete cycle in clk cycles.
- Publishes both measurements with a one-cycle valid strobe.
- Flags an input stuck high or stuck low.
- Used for loopback checking of phased channels and for capturing externally driven PWM.

Parameters:
- CTR_W, 11, width of the internal counter and both measurement outputs.
- TIMEOUT, 2047, cycles without a terminating edge before a stuck flag is raised. Must be at most 2^CTR_W-1.
- SYNC_STAGES, 2, number of input synchroniser flops. Minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low. rst=0 resets all state immediately.
- pwm_in  in  1  asynchronous PWM input.
- high_cnt  out  CTR_W  high time of the last complete cycle, in clk cycles.
- period_cnt  out  CTR_W  rise-to-rise period of the last complete cycle, in clk cycles.
- valid  out  1  one-cycle pulse when high_cnt/period_cnt update.
- stuck_hi  out  1  input has been high for TIMEOUT cycles.
- stuck_lo  out  1  input has been low for TIMEOUT cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchroniser flops, edge-history flop, cnt, hi_len, high_cnt, period_cnt, valid, stuck_hi, stuck_lo all go to 0.
  - State goes to IDLE.
- Synchroniser and edge detect:
  - pwm_in passes through SYNC_STAGES flops to give s; s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - A pwm_in rise meeting setup before clk edge k gives rise=1 after edge k+SYNC_STAGES-1.
- cnt (CTR_W bits):
  - Loads 1 on any cycle with rise=1.
  - Otherwise increments in HIGH/LOW and saturates at TIMEOUT.
  - Holds 0 in IDLE.
- Result: cnt equals the number of clk cycles since the last rise.
- FSM states are IDLE, HIGH, LOW.
  - IDLE (after reset or timeout):
    - rise -> HIGH, cnt=1, stuck_lo cleared, no valid.
    - fall is ignored apart from stuck_hi clearing.
  - HIGH:
    - fall -> LOW, hi_len<=cnt.
    - If cnt==TIMEOUT with no fall that cycle -> IDLE, stuck_hi<=1.
  - LOW:
    - rise -> HIGH, high_cnt<=hi_len, period_cnt<=cnt, valid<=1, cnt<=1, stuck_lo<=0.
    - If cnt==TIMEOUT with no rise that cycle -> IDLE, stuck_lo<=1.
- Priority: an edge in the same cycle as cnt==TIMEOUT wins; no stuck flag is raised. A period of exactly TIMEOUT is therefore measured normally.
- stuck_hi clears on the first fall in any state. stuck_lo clears on the first rise in any state. Both flags are never 1 together.
- valid:
  - Registered, exactly one cycle wide.
  - Asserts after edge k+SYNC_STAGES for the pwm_in rise that closes the cycle.
  - The first rise after reset or after IDLE never produces valid; two rises are needed.
- high_cnt/period_cnt hold their last published values between valid pulses and through stuck conditions.
- Invariant: 1 <= high_cnt < period_cnt whenever valid=1.
- Width rule: no wrap-around is possible, because cnt saturates at TIMEOUT and TIMEOUT <= 2^CTR_W-1.
- Generator mapping: compare C in 1..1250 at 1251-cycle framing gives high_cnt=C, period_cnt=1251.
- Generator extremes: C=0 is constant low and raises stuck_lo. C>=1251 is constant high and raises stuck_hi.

Test Plan:
- Drive pwm_in high 625 / low 626 cycles, repeating -> first valid on the 2nd rise, then every 1251 cycles; high_cnt=625, period_cnt=1251, stuck flags 0.
- Drive high 1 / low 1250 cycles -> high_cnt=1, period_cnt=1251. Then high 1250 / low 1 cycles -> high_cnt=1250, period_cnt=1251.
- Rise, then hold high -> stuck_hi=1 exactly when cnt reaches 2047, no valid, high_cnt/period_cnt unchanged. Then drop low -> stuck_hi=0 SYNC_STAGES cycles later; next rise gives no valid, the following rise gives valid.
- Period boundary, high 100: period 2047 -> valid with period_cnt=2047, no stuck. Period 2048 -> stuck_lo=1 at cnt 2047, no valid; the next rise clears stuck_lo without valid.
- Assert rst=0 mid-high-phase between clock edges -> all outputs 0 immediately. Release with pwm_in running -> first rise produces no valid; the second rise produces a correct measurement.
- Async stimulus: pwm_in edges at random sub-cycle offsets, 50 periods of 1251 -> every period_cnt in 1250..1252, every high_cnt within ±1 of the driven high time.
